des_tdm_scheduler: RTL and testbench

//  Multi-channel front end for the pipelined 16-round DES datapath. Arbitrates CHANNELS plaintext

---
 rtl/des_tdm_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_des_tdm_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_tdm_scheduler.sv
// des_tdm_scheduler
// Round-robin front end that shares one fixed-latency DES core between
// CHANNELS plaintext sources. Each issued block carries its channel ID through
// a tag pipe that runs alongside the core. Each returning ciphertext is steered
// into that channel's output FIFO. A per-channel credit (blocks in flight plus
// blocks buffered) stops new issue before a buffer could overflow, so a stalled
// sink never blocks the other channels.

module des_tdm_scheduler #(
   parameter int CHANNELS  = 4,
   parameter int DATA_W    = 64,
   parameter int PIPE_LAT  = 16,
   parameter int OUT_DEPTH = 2
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       CHIP_SELECT_BAR,
   input  logic [CHANNELS-1:0]        in_valid,
   output logic [CHANNELS-1:0]        in_ready,
   input  logic [CHANNELS*DATA_W-1:0] in_data,
   output logic [DATA_W-1:0]          core_pt,
   output logic                       core_issue,
   input  logic [DATA_W-1:0]          core_ct,
   output logic [CHANNELS-1:0]        out_valid,
   input  logic [CHANNELS-1:0]        out_ready,
   output logic [CHANNELS*DATA_W-1:0] out_data,
   output logic                       busy
);

   localparam int CW  = $clog2(CHANNELS);
   localparam int CRW = $clog2(OUT_DEPTH + 1);
   localparam int AW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

   localparam logic [CRW-1:0] DEPTH_C   = CRW'(OUT_DEPTH);
   localparam logic [AW-1:0]  LAST_SLOT = AW'(OUT_DEPTH - 1);
   localparam logic [CW-1:0]  LAST_CHAN = CW'(CHANNELS - 1);

   // One tag per core stage. valid=0 marks a bubble.
   typedef struct packed {
      logic          valid;
      logic [CW-1:0] chan;
   } tag_t;

   // Arbiter and issue state
   logic [CW-1:0]     ptr;
   logic [CW-1:0]     issue_chan;
   tag_t              tag_pipe [PIPE_LAT];

   // Per-channel credit and output FIFO state
   logic [CRW-1:0]    credit [CHANNELS];
   logic [CRW-1:0]    occ    [CHANNELS];
   logic [AW-1:0]     wr_ptr [CHANNELS];
   logic [AW-1:0]     rd_ptr [CHANNELS];
   logic [DATA_W-1:0] mem    [CHANNELS][OUT_DEPTH];

   // Combinational decode
   logic [CHANNELS-1:0] eligible;
   logic [CHANNELS-1:0] grant;
   logic [CHANNELS-1:0] push;
   logic [CHANNELS-1:0] pop;
   logic                grant_any;
   logic [CW-1:0]       grant_id;
   logic [DATA_W-1:0]   grant_data;
   tag_t                exit_tag;

   // Advance a FIFO slot index. The index wraps at OUT_DEPTH, not at 2**AW.
   function automatic logic [AW-1:0] slot_next(input logic [AW-1:0] p);
      return (p == LAST_SLOT) ? '0 : p + AW'(1);
   endfunction

   // A channel may issue only when it has a block, has buffer room reserved, and the chip is selected.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         eligible[i] = in_valid[i] && (credit[i] < DEPTH_C) && !CHIP_SELECT_BAR && !RST;
      end
   end

   // Round-robin search: the first eligible channel at or after ptr wins.
   always_comb begin
      logic [CW:0] idx;
      // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
      grant     = '0;
      grant_any = 1'b0;
      grant_id  = '0;
      idx       = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         idx = {1'b0, ptr} + (CW+1)'(k);
         if (idx >= (CW+1)'(CHANNELS)) begin
            idx = idx - (CW+1)'(CHANNELS);
         end
         if (!grant_any && eligible[idx[CW-1:0]]) begin
            grant_any = 1'b1;
            grant_id  = idx[CW-1:0];
         end
      end
      grant[grant_id] = grant_any;
   end

   assign in_ready = grant;

   // Select the granted channel's plaintext for the issue register.
   always_comb begin
      grant_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (grant[i]) begin
            grant_data = in_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Steer the tag leaving the pipe, detect pops, and expose FIFO heads and the busy flag.
   always_comb begin
      exit_tag = tag_pipe[PIPE_LAT-1];
      out_data = '0;
      busy     = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         out_valid[i] = (occ[i] != '0);
         pop[i]       = out_valid[i] && out_ready[i];
         push[i]      = exit_tag.valid && (exit_tag.chan == CW'(i));
         out_data[i*DATA_W +: DATA_W] = out_valid[i] ? mem[i][rd_ptr[i]] : '0;
         // credit counts in-flight plus buffered blocks, so it alone says whether anything is pending.
         busy = busy || (credit[i] != '0);
      end
   end

   // Issue register: launch the granted block into the core and move the round-robin pointer past it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ptr        <= '0;
         core_pt    <= '0;
         core_issue <= 1'b0;
         issue_chan <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         core_issue <= grant_any;
         if (grant_any) begin
            core_pt    <= grant_data;
            issue_chan <= grant_id;
            ptr        <= (grant_id == LAST_CHAN) ? '0 : grant_id + CW'(1);
         end
      end
   end

   // Tag pipe: follows the issue register stage for stage, so its last entry lines up with core_ct.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int k = 0; k < PIPE_LAT; k++) begin
            tag_pipe[k] <= '0;
         end
      end else begin
         tag_pipe[0] <= '{valid: core_issue, chan: issue_chan};
         for (int k = 1; k < PIPE_LAT; k++) begin
            tag_pipe[k] <= tag_pipe[k-1];
         end
      end
   end

   // Credit and FIFO bookkeeping: a grant reserves a slot and a pop releases it; a tag exit only moves a block from in-flight to buffered.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < CHANNELS; i++) begin
            credit[i] <= '0;
            occ[i]    <= '0;
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            credit[i] <= credit[i] + CRW'(grant[i]) - CRW'(pop[i]);
            occ[i]    <= occ[i] + CRW'(push[i]) - CRW'(pop[i]);
            if (push[i]) begin
               wr_ptr[i] <= slot_next(wr_ptr[i]);
            end
            if (pop[i]) begin
               rd_ptr[i] <= slot_next(rd_ptr[i]);
            end
         end
      end
   end

   // FIFO storage: capture returning ciphertext into the tagged channel.
   // NOTE: storage is not reset; out_data is masked by out_valid, so stale words are never visible.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (push[i]) begin
            mem[i][wr_ptr[i]] <= core_ct;
         end
      end
   end

   // Credit reserves a slot at grant time, so a returning block must always find room.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_no_overflow
      a_no_overflow: assert property (@(posedge CLK) disable iff (RST) push[i] |-> (occ[i] < DEPTH_C));
   end

endmodule

// File: tb/tb_des_tdm_scheduler.sv
// Directed bench for des_tdm_scheduler with CHANNELS=4, DATA_W=64,
// PIPE_LAT=16, OUT_DEPTH=2. The DES core is modelled as a 16-stage register
// chain that XORs the plaintext with a fixed key.

module tb_des_tdm_scheduler;

   localparam int CH  = 4;
   localparam int DW  = 64;
   localparam int LAT = 16;
   localparam int DEP = 2;
   localparam logic [63:0] KEY = 64'hA5A5_A5A5_A5A5_A5A5;

   logic             clk;
   logic             rst;
   logic             chip_select_bar;
   logic [CH-1:0]    in_valid;
   logic [CH-1:0]    in_ready;
   logic [CH*DW-1:0] in_data;
   logic [DW-1:0]    core_pt;
   logic             core_issue;
   logic [DW-1:0]    core_ct;
   logic [CH-1:0]    out_valid;
   logic [CH-1:0]    out_ready;
   logic [CH*DW-1:0] out_data;
   logic             busy;

   logic [DW-1:0]    core_chain [LAT];

   int total = 0;
   int bad   = 0;

   des_tdm_scheduler #(
      .CHANNELS (CH),
      .DATA_W   (DW),
      .PIPE_LAT (LAT),
      .OUT_DEPTH(DEP)
   ) dut (
      .CLK            (clk),
      .RST            (rst),
      .CHIP_SELECT_BAR(chip_select_bar),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .core_pt        (core_pt),
      .core_issue     (core_issue),
      .core_ct        (core_ct),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core model: the ciphertext appears LAT cycles after core_pt is presented.
   always @(posedge clk) begin
      core_chain[0] <= core_pt ^ KEY;
      for (int k = 1; k < LAT; k++) core_chain[k] <= core_chain[k-1];
   end
   assign core_ct = core_chain[LAT-1];

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [63:0] od(input int ch);
      return out_data[ch*DW +: DW];
   endfunction

   task automatic set_data(input int ch, input logic [63:0] d);
      in_data[ch*DW +: DW] = d;
   endtask

   initial begin
      int results;
      int stale;
      int n;
      logic issue_seen;

      for (int k = 0; k < LAT; k++) core_chain[k] = '0;
      rst             = 1'b1;
      chip_select_bar = 1'b0;
      in_valid        = '0;
      in_data         = '0;
      out_ready       = '0;

      // ---- reset state: valid inputs are ignored while reset is held
      tick();
      in_valid = 4'hF;
      settle();
      check("rst_in_ready",   {60'b0, in_ready}, 64'h0);
      check("rst_core_issue", {63'b0, core_issue}, 64'h0);
      check("rst_core_pt",    core_pt, 64'h0);
      check("rst_out_valid",  {60'b0, out_valid}, 64'h0);
      check("rst_busy",       {63'b0, busy}, 64'h0);
      in_valid = '0;
      tick();
      rst = 1'b0;

      // ---- 1: single block on ch0, latency and data
      out_ready = 4'hF;
      set_data(0, 64'h0123_4567_89AB_CDEF);
      in_valid = 4'b0001;
      settle();
      check("t1_in_ready", {60'b0, in_ready}, 64'h1);
      tick();
      in_valid = '0;
      check("t1_core_issue", {63'b0, core_issue}, 64'h1);
      check("t1_core_pt", core_pt, 64'h0123_4567_89AB_CDEF);
      check("t1_busy_inflight", {63'b0, busy}, 64'h1);
      tick();
      check("t1_core_issue_drop", {63'b0, core_issue}, 64'h0);
      repeat (15) tick();
      check("t1_out_valid_early", {60'b0, out_valid}, 64'h0);
      tick();
      check("t1_out_valid", {60'b0, out_valid}, 64'h1);
      check("t1_out_data", od(0), 64'hA486_E0C2_2C0E_684A);
      check("t1_other_data", out_data[CH*DW-1:DW] == '0 ? 64'h0 : 64'h1, 64'h0);
      tick();
      check("t1_popped", {60'b0, out_valid}, 64'h0);
      check("t1_busy_idle", {63'b0, busy}, 64'h0);

      // ---- 2: all channels requesting, round-robin from ptr=0 until credit runs out
      do_reset();
      for (int c = 0; c < CH; c++) set_data(c, 64'h1000 + 64'(c));
      in_valid = 4'hF;
      settle();
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t2_grant_%0d", i), {60'b0, in_ready}, 64'(1 << (i % 4)));
         tick();
      end
      check("t2_credit_stall", {60'b0, in_ready}, 64'h0);
      in_valid = '0;

      // ---- 3: ch2 sink stalled, credit limits it to 2 blocks, then ordered drain
      do_reset();
      out_ready = 4'b1011;
      set_data(2, 64'hA0A0_0000_0000_0001);
      in_valid = 4'b0100;
      settle();
      check("t3_ready_1", {60'b0, in_ready}, 64'h4);
      tick();
      set_data(2, 64'hA0A0_0000_0000_0002);
      check("t3_ready_2", {60'b0, in_ready}, 64'h4);
      tick();
      set_data(2, 64'hA0A0_0000_0000_0003);
      check("t3_ready_blocked", {60'b0, in_ready}, 64'h0);
      repeat (25) tick();
      check("t3_still_blocked", {60'b0, in_ready}, 64'h0);
      check("t3_no_issue", {63'b0, core_issue}, 64'h0);
      check("t3_out_valid", {60'b0, out_valid}, 64'h4);
      check("t3_head_first", od(2), 64'hA0A0_0000_0000_0001 ^ KEY);
      out_ready = 4'hF;
      tick();
      check("t3_head_second", od(2), 64'hA0A0_0000_0000_0002 ^ KEY);
      check("t3_ready_resumed", {60'b0, in_ready}, 64'h4);
      tick();
      check("t3_reissue", {63'b0, core_issue}, 64'h1);
      check("t3_reissue_pt", core_pt, 64'hA0A0_0000_0000_0003);
      in_valid = '0;
      n = 0;
      while (busy !== 1'b0 && n < 60) begin
         tick();
         n++;
      end
      check("t3_drain", {63'b0, busy}, 64'h0);

      // ---- 4: chip deselect after 5 issues; in-flight work still completes
      do_reset();
      out_ready = 4'hF;
      for (int c = 0; c < CH; c++) set_data(c, 64'h4000 + 64'(c));
      in_valid = 4'hF;
      repeat (5) tick();
      check("t4_fifth_issue", {63'b0, core_issue}, 64'h1);
      chip_select_bar = 1'b1;
      settle();
      check("t4_ready_off", {60'b0, in_ready}, 64'h0);
      check("t4_busy", {63'b0, busy}, 64'h1);
      results    = 0;
      issue_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         results    += $countones(out_valid);
         issue_seen |= core_issue;
      end
      check("t4_results", 64'(results), 64'd5);
      check("t4_no_new_issue", {63'b0, issue_seen}, 64'h0);
      check("t4_busy_idle", {63'b0, busy}, 64'h0);
      chip_select_bar = 1'b0;
      in_valid = '0;

      // ---- 5: reset with every credit in use (3 buffered, 5 still in the core)
      do_reset();
      out_ready = '0;
      for (int c = 0; c < CH; c++) set_data(c, 64'h5000 + 64'(c));
      in_valid = 4'hF;
      repeat (8) tick();
      in_valid = '0;
      repeat (12) tick();
      check("t5_buffered", {60'b0, out_valid}, 64'h7);
      check("t5_busy", {63'b0, busy}, 64'h1);
      in_valid = 4'hF;
      rst = 1'b1;
      settle();
      check("t5_rst_in_ready", {60'b0, in_ready}, 64'h0);
      check("t5_rst_issue", {63'b0, core_issue}, 64'h0);
      check("t5_rst_pt", core_pt, 64'h0);
      check("t5_rst_out_valid", {60'b0, out_valid}, 64'h0);
      check("t5_rst_out_data", out_data == '0 ? 64'h0 : 64'h1, 64'h0);
      check("t5_rst_busy", {63'b0, busy}, 64'h0);
      tick();
      rst = 1'b0;
      in_valid = '0;
      out_ready = 4'hF;
      stale = 0;
      for (int i = 0; i < 32; i++) begin
         tick();
         stale += $countones(out_valid);
      end
      check("t5_no_stale", 64'(stale), 64'd0);
      set_data(3, 64'hFEDC_BA98_7654_3210);
      in_valid = 4'b1000;
      settle();
      check("t5_new_ready", {60'b0, in_ready}, 64'h8);
      tick();
      in_valid = '0;
      repeat (17) tick();
      check("t5_new_valid", {60'b0, out_valid}, 64'h8);
      check("t5_new_data", od(3), 64'hFEDC_BA98_7654_3210 ^ KEY);

      // ---- 6: ptr=2 with ch1 and ch3 pending; then push and pop together on ch1
      do_reset();
      out_ready = 4'b1101;
      set_data(1, 64'hB0B0_0000_0000_0000);
      in_valid = 4'b0010;
      tick();
      set_data(1, 64'hB1B1_0000_0000_0001);
      set_data(3, 64'hC0C0_0000_0000_0003);
      in_valid = 4'b1010;
      settle();
      check("t6_grant_ch3", {60'b0, in_ready}, 64'h8);
      tick();
      check("t6_grant_ch1", {60'b0, in_ready}, 64'h2);
      tick();
      in_valid = '0;
      repeat (16) tick();
      check("t6_pre_valid", {60'b0, out_valid}, 64'hA);
      check("t6_pre_head", od(1), 64'hB0B0_0000_0000_0000 ^ KEY);
      out_ready = 4'hF;
      tick();
      check("t6_pushpop_valid", {60'b0, out_valid}, 64'h2);
      check("t6_pushpop_head", od(1), 64'hB1B1_0000_0000_0001 ^ KEY);
      tick();
      check("t6_occ_one", {60'b0, out_valid}, 64'h0);
      check("t6_busy_idle", {63'b0, busy}, 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
